keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Front-panel input counterpart to the 8-digit seven-segment scan driver.
- Scans a 4x4 hex matrix keypad by driving active-low columns and sampling active-low rows.
- Debounces press and release, then emits one 4-bit hex code per press.
- Shifts each code into a 32-bit entry register whose layout matches the display's data[32:1] input, so typed digits appear directly on the display.

Parameters:
- SCAN_DIV, 2048, clk cycles per column dwell; one "tick" at the end of each dwell. Must be ≥ 4.
- DEBOUNCE, 4, consecutive identical ticks required to accept a press or a release. Range 1..15.

Ports:
- clk  input  1  system clock
- rst  input  1  reset
- row  input  4  keypad rows, active-low, asynchronous to clk
- clr  input  1  synchronous clear of entry
- col  output  4  column drive, active-low, exactly one bit low at all times
- key_valid  output  1  one-cycle pulse when a press is accepted
- key_code  output  4  hex code of the last accepted key
- key_held  output  1  high while an accepted key has not yet been released
- entry  output  32  [32:1], digit shift register; newest digit in [4:1]

Interface notes:
- One clock.
- Reset is asynchronous and active-high.

Behaviour:
- Reset values:
  - col=4'b1110 (col_idx=0)
  - key_valid=0, key_code=0, key_held=0, entry=0
  - state=SCAN, divider=0, debounce count=0, synchronizer flops=4'hF
- Row synchronizer:
  - Two-flop synchronizer on row gives rs.
  - All decisions use rs sampled on the tick cycle.
- Divider:
  - Counts 0..SCAN_DIV-1 and wraps.
  - tick=1 when the divider equals SCAN_DIV-1.
  - Free-running in every state.
- Column drive:
  - col = ~(4'b0001 << col_idx).
  - col_idx advances (mod 4, 3 wraps to 0) on a tick only in SCAN when no candidate is captured.
  - col_idx is frozen in DEBOUNCE and HELD.
- Key code: code = 4*row_idx + col_idx, where row_idx is the index of the single low bit of rs.
- State SCAN, on tick:
  - rs==4'hF, or more than one bit of rs low: advance column, stay in SCAN.
  - Exactly one bit of rs low: latch cand_row=rs, count=1, go DEBOUNCE. Column does not advance.
  - If DEBOUNCE==1, accept immediately: same actions as acceptance below, go straight to HELD.
- State DEBOUNCE, on tick:
  - rs==cand_row: count++.
  - If count reaches DEBOUNCE, accept:
    - key_valid=1 for the next cycle only
    - key_code=code
    - entry={entry[28:1],code}
    - key_held=1
    - go HELD
  - rs!=cand_row: go SCAN, advance column, no output change.
- State HELD, on tick:
  - rs==4'hF: rel_count++.
  - rs!=4'hF: rel_count=0.
  - When rel_count reaches DEBOUNCE: key_held=0, go SCAN, advance column.
  - A second key pressed while held is ignored until full release.
- key_valid timing: rises the cycle after the accepting tick. Never high two consecutive cycles.
- clr:
  - Any cycle: entry=0.
  - clr coincident with acceptance: entry={28'b0,code}; key_valid still pulses.
  - clr does not affect state, key_code or key_held.
- rst mid-operation: everything returns to reset values immediately; no key_valid is emitted for a partially debounced key.
- Width rules:
  - count and rel_count are 4-bit and saturate at DEBOUNCE.
  - entry shift discards bits [32:29].

Test Plan:
1. Bench setup for all scenarios:
   - SCAN_DIV=8, DEBOUNCE=3.
   - Keypad model: row[r]=0 iff key (r,c) is pressed and col[c]==0.
2. Reset, then press (r1,c2) and hold → exactly one key_valid pulse; key_code=6, entry=32'h00000006, key_held=1. Release → key_held=0 after 3 clear ticks; col resumes rotating.
3. After scenario 2, press (r3,c3) and release, then press (r0,c0) and release → entry=32'h0000006F, then 32'h000006F0.
4. Bounce: key (r2,c1) low for exactly one dwell, then released → state returns to SCAN; no key_valid, entry unchanged.
5. Press (r0,c1) and (r2,c1) together, both held → no key_valid; column keeps rotating.
6. Boundary cases:
   - Type 9 digits 1..9 → entry=32'h23456789 (shift wrap).
   - Assert clr on the same cycle as acceptance of key A → entry=32'h0000000A.
   - Assert rst while in HELD → all outputs return to reset values, col=4'b1110.

Source files
------------

// File: rtl/keypad_scanner_if.sv
// Keypad scanner bus: matrix drive/sense lines, clear request and decoded-key outputs.
// The master is the keypad/host side, the slave is the scanner.
interface keypad_scanner_if;
    logic [3:0]  row;
    logic        clr;
    logic [3:0]  col;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_held;
    logic [31:0] entry;

    modport master (
        output row, clr,
        input  col, key_valid, key_code, key_held, entry
    );

    modport slave (
        input  row, clr,
        output col, key_valid, key_code, key_held, entry
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: rotating active-low column drive, debounced press/release,
// one code per press shifted into a display-compatible 32-bit entry register.
module keypad_scanner #(
    parameter int SCAN_DIV = 2048,
    parameter int DEBOUNCE = 4
) (
    input  logic              clk,
    input  logic              rst,
    keypad_scanner_if.slave   bus
);
    localparam int DW = $clog2(SCAN_DIV);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [1:0]  col_idx_q, col_idx_d;
    logic [3:0]  row_s1_q, rs_q;
    logic [3:0]  cand_row_q, cand_row_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  rel_cnt_q, rel_cnt_d;
    logic        key_valid_q, key_valid_d;
    logic [3:0]  key_code_q, key_code_d;
    logic        key_held_q, key_held_d;
    logic [31:0] entry_q, entry_d;

    logic        tick_s;
    logic        single_s;
    logic        accept_s;
    logic        advance_s;
    logic [3:0]  code_s;

    // True when exactly one row line is pulled low.
    function automatic logic one_low(input logic [3:0] r);
        logic [3:0] inv;
        inv = ~r;
        return (inv != 4'd0) && ((inv & (inv - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [1:0] row_index(input logic [3:0] r);
        logic [1:0] idx;
        case (r)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    assign tick_s   = (div_q == DW'(SCAN_DIV - 1));
    assign single_s = one_low(rs_q);
    assign code_s   = {row_index(rs_q), col_idx_q};

    // Two-flop synchronizer for the asynchronous row inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_s1_q <= 4'hF;
            rs_q     <= 4'hF;
        end else begin
            row_s1_q <= bus.row;
            rs_q     <= row_s1_q;
        end
    end

    // Scan/debounce state register and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_SCAN;
            div_q       <= '0;
            col_idx_q   <= 2'd0;
            cand_row_q  <= 4'hF;
            cnt_q       <= 4'd0;
            rel_cnt_q   <= 4'd0;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'd0;
            key_held_q  <= 1'b0;
            entry_q     <= 32'd0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            col_idx_q   <= col_idx_d;
            cand_row_q  <= cand_row_d;
            cnt_q       <= cnt_d;
            rel_cnt_q   <= rel_cnt_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            key_held_q  <= key_held_d;
            entry_q     <= entry_d;
        end
    end

    // Next-state logic: all decisions are taken on the tick at the end of a column dwell.
    always_comb begin
        state_d     = state_q;
        div_d       = tick_s ? '0 : div_q + DW'(1);
        cand_row_d  = cand_row_q;
        cnt_d       = cnt_q;
        rel_cnt_d   = rel_cnt_q;
        key_code_d  = key_code_q;
        key_held_d  = key_held_q;
        key_valid_d = 1'b0;
        accept_s    = 1'b0;
        advance_s   = 1'b0;

        if (tick_s) begin
            case (state_q)
                ST_SCAN: begin
                    if (single_s) begin
                        cand_row_d = rs_q;
                        cnt_d      = 4'd1;
                        if (DEBOUNCE == 1) begin
                            accept_s = 1'b1;
                        end else begin
                            state_d = ST_DEBOUNCE;
                        end
                    end else begin
                        advance_s = 1'b1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (rs_q == cand_row_q) begin
                        if ((cnt_q + 4'd1) >= 4'(DEBOUNCE)) begin
                            accept_s = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end else begin
                        state_d   = ST_SCAN;
                        advance_s = 1'b1;
                    end
                end
                ST_HELD: begin
                    if (rs_q == 4'hF) begin
                        if ((rel_cnt_q + 4'd1) >= 4'(DEBOUNCE)) begin
                            rel_cnt_d  = 4'd0;
                            key_held_d = 1'b0;
                            state_d    = ST_SCAN;
                            advance_s  = 1'b1;
                        end else begin
                            rel_cnt_d = rel_cnt_q + 4'd1;
                        end
                    end else begin
                        rel_cnt_d = 4'd0;
                    end
                end
                default: begin
                    state_d = ST_SCAN;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        if (accept_s) begin
            state_d     = ST_HELD;
            cnt_d       = 4'(DEBOUNCE);
            rel_cnt_d   = 4'd0;
            key_valid_d = 1'b1;
            key_code_d  = code_s;
            key_held_d  = 1'b1;
        end else begin
            key_valid_d = 1'b0;
        end

        // A clear on the accepting tick still keeps the newly accepted digit.
        if (accept_s) begin
            entry_d = bus.clr ? {28'd0, code_s} : {entry_q[27:0], code_s};
        end else if (bus.clr) begin
            entry_d = 32'd0;
        end else begin
            entry_d = entry_q;
        end

        col_idx_d = advance_s ? col_idx_q + 2'd1 : col_idx_q;
    end

    assign bus.col       = ~(4'b0001 << col_idx_q);
    assign bus.key_valid = key_valid_q;
    assign bus.key_code  = key_code_q;
    assign bus.key_held  = key_held_q;
    assign bus.entry     = entry_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed and randomized bench for keypad_scanner with a key-matrix model and
// a digit-level reference model of the entry register.
module tb_keypad_scanner;
    logic        clk;
    logic        rst;
    logic [15:0] pressed;
    int          checks;
    int          errors;
    int          pulse_cnt;
    int          consec_cnt;
    logic        prev_kv;
    logic [31:0] model_entry;

    keypad_scanner_if kp ();

    keypad_scanner #(.SCAN_DIV(8), .DEBOUNCE(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (kp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Key matrix: row r reads low when a pressed key in that row sits on the driven column.
    always_comb begin
        logic [3:0] r_v;
        r_v = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4 + c] && !kp.col[c]) r_v[r] = 1'b0;
            end
        end
        kp.row = r_v;
    end

    // Count key_valid pulses and back-to-back pulses.
    always @(negedge clk) begin
        if (kp.key_valid) pulse_cnt <= pulse_cnt + 1;
        if (kp.key_valid && prev_kv) consec_cnt <= consec_cnt + 1;
        prev_kv <= kp.key_valid;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Key at matrix position (r,c) reports 4*r + c.
    function automatic logic [3:0] key_code_of(input int r, input int c);
        return 4'(4 * r + c);
    endfunction

    task automatic press_key(input int r, input int c);
        int p0;
        logic [3:0] code;
        code = key_code_of(r, c);
        p0 = pulse_cnt;
        pressed[r*4 + c] = 1'b1;
        repeat (150) @(negedge clk);
        chk("press_pulses", 32'(pulse_cnt - p0), 32'd1);
        chk("press_code", {28'd0, kp.key_code}, {28'd0, code});
        model_entry = {model_entry[27:0], code};
        chk("press_entry", kp.entry, model_entry);
        chk("press_held", {31'd0, kp.key_held}, 32'd1);
        pressed[r*4 + c] = 1'b0;
        repeat (60) @(negedge clk);
        chk("release_held", {31'd0, kp.key_held}, 32'd0);
    endtask

    task automatic check_rotation(input int cycles);
        logic [3:0] seen;
        logic       bad;
        seen = 4'd0;
        bad  = 1'b0;
        repeat (cycles) begin
            @(negedge clk);
            case (kp.col)
                4'b1110: seen[0] = 1'b1;
                4'b1101: seen[1] = 1'b1;
                4'b1011: seen[2] = 1'b1;
                4'b0111: seen[3] = 1'b1;
                default: bad = 1'b1;
            endcase
        end
        chk("col_rotate", {28'd0, seen}, 32'hF);
        chk("col_onehot", {31'd0, bad}, 32'd0);
    endtask

    initial begin
        int p0;
        int k;
        int budget;
        checks      = 0;
        errors      = 0;
        pulse_cnt   = 0;
        consec_cnt  = 0;
        prev_kv     = 1'b0;
        pressed     = 16'd0;
        model_entry = 32'd0;
        kp.clr      = 1'b0;
        rst         = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_col", {28'd0, kp.col}, 32'hE);
        chk("rst_valid", {31'd0, kp.key_valid}, 32'd0);
        chk("rst_code", {28'd0, kp.key_code}, 32'd0);
        chk("rst_held", {31'd0, kp.key_held}, 32'd0);
        chk("rst_entry", kp.entry, 32'd0);
        rst = 1'b0;
        check_rotation(40);

        // Single press, then two more keys shifting in.
        press_key(1, 2);
        chk("entry_6", kp.entry, 32'h6);
        check_rotation(40);
        press_key(3, 3);
        chk("entry_6F", kp.entry, 32'h6F);
        press_key(0, 0);
        chk("entry_6F0", kp.entry, 32'h6F0);

        // Bounce: (r2,c1) low for exactly one column-1 dwell.
        budget = 0;
        while (kp.col != 4'b1101 && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        chk("bounce_col_found", {31'd0, (kp.col == 4'b1101)}, 32'd1);
        p0 = pulse_cnt;
        pressed[2*4 + 1] = 1'b1;
        repeat (8) @(negedge clk);
        pressed[2*4 + 1] = 1'b0;
        repeat (60) @(negedge clk);
        chk("bounce_pulses", 32'(pulse_cnt - p0), 32'd0);
        chk("bounce_entry", kp.entry, model_entry);
        chk("bounce_held", {31'd0, kp.key_held}, 32'd0);
        check_rotation(40);

        // Two keys in the same column: ambiguous, never accepted.
        p0 = pulse_cnt;
        pressed[0*4 + 1] = 1'b1;
        pressed[2*4 + 1] = 1'b1;
        repeat (100) @(negedge clk);
        check_rotation(40);
        chk("multi_pulses", 32'(pulse_cnt - p0), 32'd0);
        chk("multi_entry", kp.entry, model_entry);
        pressed = 16'd0;
        repeat (30) @(negedge clk);

        // Nine digits 1..9: oldest digit falls off the top.
        for (int d = 1; d <= 9; d++) press_key(d / 4, d % 4);
        chk("entry_wrap", kp.entry, 32'h23456789);

        // Random keys against the digit model.
        for (int i = 0; i < 6; i++) begin
            k = $urandom_range(0, 15);
            press_key(k / 4, k % 4);
        end

        // Clear held across acceptance of key A.
        kp.clr = 1'b1;
        repeat (2) @(negedge clk);
        chk("clr_entry", kp.entry, 32'd0);
        pressed[2*4 + 2] = 1'b1;
        budget = 0;
        while (!kp.key_valid && budget < 150) begin
            @(negedge clk);
            budget++;
        end
        kp.clr = 1'b0;
        chk("clrA_valid", {31'd0, kp.key_valid}, 32'd1);
        chk("clrA_code", {28'd0, kp.key_code}, 32'hA);
        @(negedge clk);
        chk("clrA_entry", kp.entry, 32'h0000000A);
        pressed = 16'd0;
        repeat (60) @(negedge clk);

        // Reset while a key is held.
        pressed[1*4 + 1] = 1'b1;
        budget = 0;
        while (!kp.key_held && budget < 150) begin
            @(negedge clk);
            budget++;
        end
        chk("held_before_rst", {31'd0, kp.key_held}, 32'd1);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstH_col", {28'd0, kp.col}, 32'hE);
        chk("rstH_valid", {31'd0, kp.key_valid}, 32'd0);
        chk("rstH_code", {28'd0, kp.key_code}, 32'd0);
        chk("rstH_held", {31'd0, kp.key_held}, 32'd0);
        chk("rstH_entry", kp.entry, 32'd0);
        pressed = 16'd0;
        repeat (3) @(negedge clk);
        p0 = pulse_cnt;
        rst = 1'b0;
        repeat (60) @(negedge clk);
        chk("post_rst_pulses", 32'(pulse_cnt - p0), 32'd0);

        chk("kv_consecutive", 32'(consec_cnt), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
